rbm_gibbs_layer: RTL

Parametrised, bidirectional successor to the single-direction RBM layer. One shared weight matrix serves both directions: visible→hidden (v→h) and hidden→visible (h→v, transposed indexing), so a single instance runs a full Gibbs step. Each pass evaluates LANES output neurons in parallel, accumulates CHUNK inputs per cycle with saturating arithmetic, and samples each neuron either stochastically or deterministically. It sits between the input-bit register and the next layer or reconstruction stage, and uses the `sigmoid` helper module.

---
 rtl/rbm_gibbs_layer.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/rbm_gibbs_layer.sv
// Bidirectional RBM layer: one shared weight matrix drives both v->h and h->v passes,
// evaluating LANES neurons per group with per-term saturating accumulation.

module sigmoid #(
  parameter int IN_BITS  = 16,
  parameter int OUT_BITS = 8
) (
  input  logic signed [IN_BITS-1:0]  i_x,
  output logic        [OUT_BITS-1:0] o_y
);
  localparam logic signed [IN_BITS:0] C_MID = (IN_BITS+1)'(1 << (OUT_BITS-1));
  localparam logic signed [IN_BITS:0] C_MAX = (IN_BITS+1)'((1 << OUT_BITS) - 1);

  logic signed [IN_BITS:0] w_lin;

  // Hard sigmoid: slope 1/16 centred on mid-scale, clamped to the output range.
  assign w_lin = ($signed({i_x[IN_BITS-1], i_x}) >>> 4) + C_MID;

  always_comb begin
    if (w_lin[IN_BITS])     o_y = '0;
    else if (w_lin > C_MAX) o_y = '1;
    else                    o_y = w_lin[OUT_BITS-1:0];
  end
endmodule

module rbm_gibbs_layer #(
  parameter int VIS_DIM  = 15,
  parameter int HID_DIM  = 5,
  parameter int W_BITS   = 12,
  parameter int ACC_BITS = 16,
  parameter int SIG_BITS = 8,
  parameter int LANES    = 1,
  parameter int CHUNK    = 4,
  localparam int MAXD    = (VIS_DIM > HID_DIM) ? VIS_DIM : HID_DIM
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      start,
  input  logic                      dir,
  input  logic                      det_mode,
  input  logic [MAXD-1:0]           in_bits,
  input  logic [LANES*SIG_BITS-1:0] rand_data,
  output logic [MAXD-1:0]           out_bits,
  output logic                      busy,
  output logic                      done
);
  localparam int MI_W = (MAXD > 1) ? $clog2(MAXD) : 1;
  localparam int VI_W = (VIS_DIM > 1) ? $clog2(VIS_DIM) : 1;
  localparam int HI_W = (HID_DIM > 1) ? $clog2(HID_DIM) : 1;
  localparam int CW   = $clog2(MAXD + 1) + 1;
  localparam int K_VH = (VIS_DIM + CHUNK - 1) / CHUNK;
  localparam int K_HV = (HID_DIM + CHUNK - 1) / CHUNK;
  localparam int G_VH = (HID_DIM + LANES - 1) / LANES;
  localparam int G_HV = (VIS_DIM + LANES - 1) / LANES;

  localparam logic signed [ACC_BITS-1:0] ACC_MAX = {1'b0, {(ACC_BITS-1){1'b1}}};
  localparam logic signed [ACC_BITS-1:0] ACC_MIN = {1'b1, {(ACC_BITS-1){1'b0}}};

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_BIAS   = 2'd1;
  localparam logic [1:0] S_ACC    = 2'd2;
  localparam logic [1:0] S_SAMPLE = 2'd3;

  // Parameter memories have no write port; the simulation environment loads them.
  logic signed [W_BITS-1:0]   r_weight [VIS_DIM][HID_DIM];
  logic signed [W_BITS-1:0]   r_vbias  [VIS_DIM];
  logic signed [W_BITS-1:0]   r_hbias  [HID_DIM];

  logic [1:0]                 r_state;
  logic                       r_dir;
  logic                       r_det;
  logic [MAXD-1:0]            r_in;
  logic [MAXD-1:0]            r_out;
  logic                       r_busy;
  logic                       r_done;
  logic [CW-1:0]              r_k;
  logic [CW-1:0]              r_grp;
  logic signed [ACC_BITS-1:0] r_acc [LANES];

  logic signed [ACC_BITS-1:0] w_next  [LANES];
  logic signed [ACC_BITS-1:0] w_bias  [LANES];
  logic [SIG_BITS-1:0]        w_sig   [LANES];
  logic                       w_valid [LANES];
  logic [MI_W-1:0]            w_idx   [LANES];
  logic                       w_bit   [LANES];
  logic                       w_k_last;
  logic                       w_g_last;

  function automatic logic signed [ACC_BITS-1:0] sat_add(
    input logic signed [ACC_BITS-1:0] a,
    input logic signed [ACC_BITS-1:0] b
  );
    logic signed [ACC_BITS:0] s;
    s = {a[ACC_BITS-1], a} + {b[ACC_BITS-1], b};
    if (s[ACC_BITS] != s[ACC_BITS-1]) return s[ACC_BITS] ? ACC_MIN : ACC_MAX;
    return s[ACC_BITS-1:0];
  endfunction

  // Transposed indexing for h->v lets both directions share one matrix.
  function automatic logic signed [ACC_BITS-1:0] term_at(input int i, input int n);
    logic signed [W_BITS-1:0] w;
    w = '0;
    if (!r_dir) begin
      if (i < VIS_DIM && n < HID_DIM && r_in[MI_W'(i)]) w = r_weight[VI_W'(i)][HI_W'(n)];
    end else begin
      if (i < HID_DIM && n < VIS_DIM && r_in[MI_W'(i)]) w = r_weight[VI_W'(n)][HI_W'(i)];
    end
    return {{(ACC_BITS-W_BITS){w[W_BITS-1]}}, w};
  endfunction

  function automatic logic signed [ACC_BITS-1:0] chunk_sum(
    input logic signed [ACC_BITS-1:0] a,
    input int                         n
  );
    logic signed [ACC_BITS-1:0] s;
    s = a;
    for (int c = 0; c < CHUNK; c++) s = sat_add(s, term_at(int'(r_k) * CHUNK + c, n));
    return s;
  endfunction

  function automatic logic signed [ACC_BITS-1:0] bias_at(input int n);
    logic signed [W_BITS-1:0] b;
    b = '0;
    if (!r_dir) begin
      if (n < HID_DIM) b = r_hbias[HI_W'(n)];
    end else begin
      if (n < VIS_DIM) b = r_vbias[VI_W'(n)];
    end
    return {{(ACC_BITS-W_BITS){b[W_BITS-1]}}, b};
  endfunction

  for (genvar gl = 0; gl < LANES; gl++) begin : g_sig
    sigmoid #(.IN_BITS(ACC_BITS), .OUT_BITS(SIG_BITS)) u_sig (
      .i_x (r_acc[gl]),
      .o_y (w_sig[gl])
    );
  end

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      w_next[l]  = chunk_sum(r_acc[l], int'(r_grp) * LANES + l);
      w_bias[l]  = bias_at(int'(r_grp) * LANES + l);
      w_valid[l] = (int'(r_grp) * LANES + l) < (r_dir ? VIS_DIM : HID_DIM);
      w_idx[l]   = MI_W'(int'(r_grp) * LANES + l);
      w_bit[l]   = r_det ? ~r_acc[l][ACC_BITS-1]
                         : (w_sig[l] > rand_data[l*SIG_BITS +: SIG_BITS]);
    end
  end

  assign w_k_last = int'(r_k)   == (r_dir ? K_HV : K_VH) - 1;
  assign w_g_last = int'(r_grp) == (r_dir ? G_HV : G_VH) - 1;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_dir   <= 1'b0;
      r_det   <= 1'b0;
      r_in    <= '0;
      r_out   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_k     <= '0;
      r_grp   <= '0;
      for (int l = 0; l < LANES; l++) r_acc[l] <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_dir   <= dir;
            r_det   <= det_mode;
            r_in    <= in_bits;
            r_out   <= '0;
            r_busy  <= 1'b1;
            r_grp   <= '0;
            r_state <= S_BIAS;
          end
        end
        S_BIAS: begin
          for (int l = 0; l < LANES; l++) r_acc[l] <= w_bias[l];
          r_k     <= '0;
          r_state <= S_ACC;
        end
        S_ACC: begin
          for (int l = 0; l < LANES; l++) r_acc[l] <= w_next[l];
          r_k <= r_k + CW'(1);
          if (w_k_last) r_state <= S_SAMPLE;
        end
        S_SAMPLE: begin
          for (int l = 0; l < LANES; l++)
            if (w_valid[l]) r_out[w_idx[l]] <= w_bit[l];
          if (w_g_last) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_grp   <= r_grp + CW'(1);
            r_state <= S_BIAS;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign out_bits = r_out;
  assign busy     = r_busy;
  assign done     = r_done;
endmodule
